// File: rtl/dmem_ctrl_if.sv
// Word-wide SRAM bus between the data-memory controller (master) and the
// memory (slave). The controller holds mem_req high until mem_ack.
interface dmem_ctrl_if #(
    parameter int AW = 30
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access stage: turns a core load/store into a req/ack access on a
// multi-cycle word SRAM, builds byte enables and lane-replicated store data,
// extends load data, and stalls the core until the access retires.
module dmem_ctrl #(
    parameter int AW      = 30,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_dmtype,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_misalign,
    output logic        mem_timeout,
    dmem_ctrl_if.master mem
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Load-side context kept for the duration of an access.
    typedef struct packed {
        logic [2:0] dmtype;
        logic [1:0] off;
    } ld_ctx_t;

    state_t         state;
    ld_ctx_t        ld_ctx;
    logic [CW-1:0]  cnt;

    logic           is_byte;
    logic           is_half;
    logic           misal_raw;
    logic [3:0]     st_be;
    logic [31:0]    st_wdata;
    logic [3:0][7:0] rd_lane;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    ld_ext;

    // Access width decode; unknown codes fall through to word.
    always_comb begin
        is_byte = (cpu_dmtype == DM_B) || (cpu_dmtype == DM_BU);
        is_half = (cpu_dmtype == DM_H) || (cpu_dmtype == DM_HU);
    end

    // Natural alignment: bytes always, halves on even, words on multiple of 4.
    always_comb begin
        if (is_byte)
            misal_raw = 1'b0;
        else if (is_half)
            misal_raw = cpu_addr[0];
        else
            misal_raw = |cpu_addr[1:0];
    end

    assign cpu_misalign = cpu_req & misal_raw;
    // A misaligned access retires at once as a no-op, so it never stalls.
    assign cpu_stall    = cpu_req & (state != DONE) & ~cpu_misalign;

    // Store byte enables and replicated data; loads carry no byte enables.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = cpu_wdata;
        if (is_byte) begin
            st_be    = 4'b0001 << cpu_addr[1:0];
            st_wdata = {4{cpu_wdata[7:0]}};
        end else if (is_half) begin
            st_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{cpu_wdata[15:0]}};
        end
        if (!cpu_we)
            st_be = 4'b0000;
    end

    // Split the raw read word into byte lanes.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign rd_lane[g] = mem.mem_rdata[8*g +: 8];
    end

    // Pick the addressed lane and sign/zero-extend according to the latched width.
    always_comb begin
        byte_sel = rd_lane[ld_ctx.off];
        half_sel = ld_ctx.off[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};
        case (ld_ctx.dmtype)
            DM_B:    ld_ext = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   ld_ext = {24'd0, byte_sel};
            DM_H:    ld_ext = {{16{half_sel[15]}}, half_sel};
            DM_HU:   ld_ext = {16'd0, half_sel};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    // Access sequencer: IDLE accepts, REQ waits for ack or timeout, DONE retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ld_ctx        <= '0;
            cnt           <= '0;
            cpu_rdata     <= '0;
            mem_timeout   <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= 4'b0000;
            mem.mem_wdata <= '0;
        end else begin
            mem_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    cpu_rdata <= '0;
                    if (cpu_req && !cpu_misalign) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= cpu_we;
                        mem.mem_addr  <= cpu_addr[AW+1:2];
                        mem.mem_be    <= st_be;
                        mem.mem_wdata <= st_wdata;
                        ld_ctx.dmtype <= cpu_dmtype;
                        ld_ctx.off    <= cpu_addr[1:0];
                        cnt           <= '0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        cpu_rdata   <= mem.mem_we ? 32'd0 : ld_ext;
                        state       <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Give up: the core retires with zero data, a store is dropped.
                        mem.mem_req <= 1'b0;
                        cpu_rdata   <= '0;
                        mem_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cpu_rdata <= '0;
                    state     <= IDLE;
                end
                default: begin
                    mem.mem_req <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios followed by random
// load/store traffic against a byte-oriented reference memory model.
module tb_dmem_ctrl;
    localparam int AW      = 30;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_dmtype;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_misalign;
    logic        mem_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [16];

    dmem_ctrl_if #(.AW(AW)) mem_bus ();

    dmem_ctrl #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_dmtype   (cpu_dmtype),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .cpu_misalign (cpu_misalign),
        .mem_timeout  (mem_timeout),
        .mem          (mem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---- reference model: access size in bytes ----
    function automatic int dsize(input logic [2:0] dt);
        case (dt)
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] dt, input logic [31:0] a);
        int mask;
        if (!we) return 4'b0000;
        mask = ((1 << dsize(dt)) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] dt, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = dsize(dt);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] dt, input logic [31:0] a);
        logic [63:0] v;
        int sz;
        sz = dsize(dt);
        v  = ({32'd0, word} >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 64'd1);
        if ((dt == 3'd1 || dt == 3'd3) && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    // One complete core access; ack_at = cycle of mem_ack (0 = never), hold = keep cpu_req up.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] dt, input int ack_at, input logic hold,
                          output logic [31:0] rd, output int stalls);
        logic        mis, acked, done;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd;
        int          idx;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_dmtype = dt;
        mis = (a % dsize(dt)) != 0;
        ebe = m_be(we, dt, a);
        ewd = m_wdata(dt, wd);
        idx = int'(a[5:2]);
        erd = 32'd0;
        stalls = 0;
        rd = 32'd0;
        #1;
        chk("misalign", cpu_misalign, mis);
        if (cpu_stall) stalls++;
        if (mis) begin
            chk("mis_stall", cpu_stall, 1'b0);
            @(negedge clk);
            cpu_req = 1'b0;
            #1;
            chk("mis_noreq", mem_bus.mem_req, 1'b0);
            chk("mis_rdata", cpu_rdata, 32'd0);
            rd = cpu_rdata;
            return;
        end
        chk("stall_c0", cpu_stall, 1'b1);
        acked = 1'b0;
        done  = 1'b0;
        for (int c = 1; c <= TIMEOUT + 1 && !done; c++) begin
            @(negedge clk);
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = $urandom;
            if (!hold) cpu_req = 1'b0;
            #1;
            if (cpu_stall) stalls++;
            if (acked || c == TIMEOUT + 1) begin
                chk("done_req", mem_bus.mem_req, 1'b0);
                chk("done_stall", cpu_stall, 1'b0);
                chk("done_timeout", mem_timeout, !acked);
                chk("done_rdata", cpu_rdata, erd);
                rd   = cpu_rdata;
                done = 1'b1;
            end else begin
                chk("req_hi", mem_bus.mem_req, 1'b1);
                chk("req_stall", cpu_stall, cpu_req);
                chk("req_timeout", mem_timeout, 1'b0);
                if (c == 1) begin
                    chk("mem_we", mem_bus.mem_we, we);
                    chk("mem_addr", 32'(mem_bus.mem_addr), a >> 2);
                    chk("mem_be", mem_bus.mem_be, ebe);
                    if (we) chk("mem_wdata", mem_bus.mem_wdata, ewd);
                end
                if (c == ack_at) begin
                    mem_bus.mem_ack = 1'b1;
                    if (we) begin
                        for (int i = 0; i < 4; i++)
                            if (ebe[i]) ref_mem[idx][8*i +: 8] = ewd[8*i +: 8];
                    end else begin
                        mem_bus.mem_rdata = ref_mem[idx];
                        erd = m_load(ref_mem[idx], dt, a);
                    end
                    acked = 1'b1;
                end
            end
        end
        if (!done) chk("access_bound", 32'd0, 32'd1);
    endtask

    // Idle cycles with stray acks, which must not start anything.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            mem_bus.mem_ack = 1'($urandom_range(0, 1));
            #1;
            chk("idle_req", mem_bus.mem_req, 1'b0);
            chk("idle_stall", cpu_stall, 1'b0);
        end
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          sc;
        int          ack;
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_dmtype = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", mem_bus.mem_req, 1'b0);
        chk("rst_we", mem_bus.mem_we, 1'b0);
        chk("rst_be", mem_bus.mem_be, 4'b0000);
        chk("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
        chk("rst_wdata", mem_bus.mem_wdata, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_timeout", mem_timeout, 1'b0);
        chk("rst_stall", cpu_stall, 1'b0);
        rst = 1'b1;

        // 1: sw @0x10 with ack at cycle 2 -> three stall cycles
        access(1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 2, 1'b1, rd, sc);
        chk("t1_stall_cycles", sc, 3);

        // 2: lb / lbu from the top byte of 0x80FFFF7F
        ref_mem[4] = 32'h80FF_FF7F;
        access(1'b0, 32'h13, 32'd0, 3'd3, 1, 1'b1, rd, sc);
        chk("t2_lb", rd, 32'hFFFFFF80);
        access(1'b0, 32'h13, 32'd0, 3'd4, 3, 1'b1, rd, sc);
        chk("t2_lbu", rd, 32'h00000080);

        // 3: sh to upper half, then misaligned lh
        access(1'b1, 32'h22, 32'h1234ABCD, 3'd1, 1, 1'b1, rd, sc);
        access(1'b0, 32'h22, 32'd0, 3'd2, 2, 1'b1, rd, sc);
        chk("t3_lhu_back", rd, 32'h0000ABCD);
        access(1'b0, 32'h21, 32'd0, 3'd1, 1, 1'b1, rd, sc);

        // 4: lw with no ack -> timeout
        access(1'b0, 32'h0, 32'd0, 3'd0, 0, 1'b1, rd, sc);
        chk("t4_rdata", rd, 32'd0);
        chk("t4_stall_cycles", sc, TIMEOUT + 1);

        // 5: reset while in REQ
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8; cpu_dmtype = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("t5_req_before", mem_bus.mem_req, 1'b1);
        rst = 1'b0;
        #1;
        chk("t5_req_async", mem_bus.mem_req, 1'b0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_req_after", mem_bus.mem_req, 1'b0);
        ref_mem[2] = 32'h0BADCAFE;
        access(1'b0, 32'h8, 32'd0, 3'd0, 2, 1'b1, rd, sc);
        chk("t5_lw", rd, 32'h0BADCAFE);

        // 6: back-to-back sw then lw on the same word
        access(1'b1, 32'h2C, 32'hCAFEF00D, 3'd0, 1, 1'b1, rd, sc);
        access(1'b0, 32'h2C, 32'd0, 3'd0, 1, 1'b1, rd, sc);
        chk("t6_lw", rd, 32'hCAFEF00D);

        // random traffic
        for (int n = 0; n < 150; n++) begin
            ack = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TIMEOUT)) : int'($urandom_range(1, 5));
            access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                   3'($urandom_range(0, 7)), ack, ($urandom_range(0, 3) != 0), rd, sc);
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
